bitstream_fetch_ctrl: RTL and testbench

Sequences the fetch of one slice of compressed bitstream from memory into bitparse. On a start pulse, it issues word reads from a base address. It buffers returned 128-bit words in a small show-ahead FIFO and raises start_dec once the buffer is primed. It then serves codec_data/codec_data_rd_en to bitparse until the slice's word count is consumed, and pulses done.

---
 rtl/bitstream_fetch_ctrl.sv | 147 ++++++++++++++
 tb/tb_bitstream_fetch_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_fetch_ctrl.sv
// Fetches one slice of compressed bitstream words from memory into a small
// show-ahead FIFO and serves them to bitparse until the slice is consumed.
module bitstream_fetch_ctrl #(
   parameter int DW    = 128,
   parameter int AW    = 16,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] cfg_base_addr,
   input  logic [AW-1:0] cfg_slice_words,
   output logic          busy,
   output logic          done,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_gnt,
   input  logic          mem_rvalid,
   input  logic [DW-1:0] mem_rdata,
   output logic          start_dec,
   input  logic          codec_data_rd_en,
   output logic [DW-1:0] codec_data,
   output logic          codec_data_valid,
   output logic          underflow_err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = CW + 1;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] base_q, len_q, issued_q, consumed_q;
   logic [CW-1:0] fifo_count, outstanding, prime_q;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [DW-1:0] fifo_mem [DEPTH];
   logic          start_dec_q, underflow_q;

   logic          start_acc, req_acc, rsp_acc, pop, underflow_hit, last_pop;
   logic [SW-1:0] credit_used;
   logic [CW-1:0] prime_nxt;

   // Requests are throttled so that buffered plus in-flight words never exceed
   // DEPTH; this is what makes an overflow impossible without a ready signal.
   assign credit_used   = SW'(fifo_count) + SW'(outstanding);
   assign start_acc     = (state == IDLE) && start;
   assign req_acc       = mem_req && mem_gnt;
   assign rsp_acc       = mem_rvalid && (outstanding != '0);
   assign pop           = codec_data_rd_en && codec_data_valid && start_dec_q;
   assign underflow_hit = codec_data_rd_en && !codec_data_valid && start_dec_q;
   assign last_pop      = pop && ((consumed_q + AW'(1)) == len_q);
   assign prime_nxt     = (cfg_slice_words >= AW'(DEPTH)) ? CW'(DEPTH) : CW'(cfg_slice_words);

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      mem_req   = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = (cfg_slice_words == '0) ? DONE : FETCH;
         end
         FETCH: begin
            busy    = 1'b1;
            mem_req = (issued_q < len_q) && (credit_used < SW'(DEPTH));
            if (last_pop)                state_nxt = DONE;
            else if (issued_q == len_q)  state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (last_pop) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         base_q      <= '0;
         len_q       <= '0;
         prime_q     <= '0;
         issued_q    <= '0;
         consumed_q  <= '0;
         outstanding <= '0;
         fifo_count  <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         start_dec_q <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state <= state_nxt;

         if (start_acc) begin
            base_q     <= cfg_base_addr;
            len_q      <= cfg_slice_words;
            prime_q    <= prime_nxt;
            issued_q   <= '0;
            consumed_q <= '0;
         end else begin
            if (req_acc) issued_q   <= issued_q + AW'(1);
            if (pop)     consumed_q <= consumed_q + AW'(1);
         end

         case ({req_acc, rsp_acc})
            2'b10:   outstanding <= outstanding + CW'(1);
            2'b01:   outstanding <= outstanding - CW'(1);
            default: outstanding <= outstanding;
         endcase

         case ({rsp_acc, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase

         if (rsp_acc) wr_ptr <= wr_ptr + PW'(1);
         if (pop)     rd_ptr <= rd_ptr + PW'(1);

         // Decode is released once the buffer holds min(DEPTH, len) words.
         if (state == DONE)
            start_dec_q <= 1'b0;
         else if (((state == FETCH) || (state == DRAIN)) && (fifo_count >= prime_q))
            start_dec_q <= 1'b1;

         if (underflow_hit) underflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rsp_acc) fifo_mem[wr_ptr] <= mem_rdata;
   end

   // Head is masked while empty so stale storage never reaches bitparse.
   assign codec_data_valid = (fifo_count != '0);
   assign codec_data       = codec_data_valid ? fifo_mem[rd_ptr] : '0;
   assign mem_addr         = base_q + issued_q;
   assign start_dec        = start_dec_q;
   assign underflow_err    = underflow_q;

endmodule

// File: tb/tb_bitstream_fetch_ctrl.sv
// Randomised bench for bitstream_fetch_ctrl: a transaction-level model of the
// slice fetch (word queues and counters) is stepped in lockstep with the DUT.
module tb_bitstream_fetch_ctrl;

   localparam int DEPTH = 4;

   logic          clk, rst, start;
   logic [15:0]   cfg_base_addr, cfg_slice_words;
   logic          busy, done, mem_req, mem_gnt, mem_rvalid;
   logic [15:0]   mem_addr;
   logic [127:0]  mem_rdata, codec_data;
   logic          start_dec, codec_data_rd_en, codec_data_valid, underflow_err;

   bitstream_fetch_ctrl #(.DW(128), .AW(16), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_base_addr(cfg_base_addr), .cfg_slice_words(cfg_slice_words),
      .busy(busy), .done(done),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .start_dec(start_dec), .codec_data_rd_en(codec_data_rd_en),
      .codec_data(codec_data), .codec_data_valid(codec_data_valid),
      .underflow_err(underflow_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Reference model state
   logic         m_busy = 0, m_done = 0, m_sd = 0, m_uf = 0;
   logic [15:0]  m_base = '0;
   int           m_len = 0, m_prime = 0, m_issued = 0, m_consumed = 0, m_out = 0;
   logic [127:0] fifo_q[$];

   // Memory-side environment
   logic [127:0] bus_dat[$];
   int           bus_due[$];
   logic [31:0]  salt = 32'h1234_0000;
   int           cyc = 0;

   // Knobs
   logic         k_rst = 1, k_start = 0, k_zero = 0, k_gnt_off = 0, k_rv_off = 0;
   logic [15:0]  k_base = '0, k_len = '0;
   int           k_gnt = 100, k_rv = 100, k_lat_min = 1, k_lat_max = 1, k_rd = 100;
   int           k_rd_hold = 0, k_gnt_hold = 0, k_noise = 0;
   int           req_wait = 0, sd_cnt = 0, n_acc = 0, n_done_seen = 0;

   function automatic logic [127:0] mkdata(input logic [15:0] a);
      logic [31:0] h;
      h = {16'h0, a} * 32'h9E37_79B1;
      return {salt, a, ~a, h, salt ^ {a, a}};
   endfunction

   task automatic cycle();
      logic        exp_req, acc, pop, uf, rv_ok, n_sd, n_busy, n_done;
      logic [15:0] ea;
      int          lat;
      @(negedge clk);
      exp_req = m_busy && !m_done && (m_issued < m_len) && ((fifo_q.size() + m_out) < DEPTH);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("mem_req", mem_req, exp_req);
      if (exp_req) begin
         ea = m_base + 16'(m_issued);
         chk("mem_addr", mem_addr, ea);
      end
      chk("start_dec", start_dec, m_sd);
      chk("data_valid", codec_data_valid, fifo_q.size() != 0);
      if (fifo_q.size() != 0) chk("codec_data", codec_data, fifo_q[0]);
      chk("underflow_err", underflow_err, m_uf);
      if (k_zero) begin
         chk("idle_data_zero", codec_data, '0);
         chk("idle_addr_zero", mem_addr, '0);
      end
      if (done) n_done_seen++;

      // Drive inputs for the coming edge
      rst   = k_rst;
      start = 1'b0;
      if (k_start) begin
         start = 1'b1; cfg_base_addr = k_base; cfg_slice_words = k_len;
      end else if (m_busy && ($urandom_range(99) < k_noise)) begin
         start = 1'b1; cfg_base_addr = 16'($urandom); cfg_slice_words = 16'($urandom);
      end
      mem_gnt = ($urandom_range(99) < k_gnt) && !k_gnt_off && (req_wait >= k_gnt_hold);
      codec_data_rd_en = ($urandom_range(99) < k_rd) && (sd_cnt >= k_rd_hold) &&
                         (m_consumed < m_len) && !m_done;
      mem_rvalid = 1'b0;
      mem_rdata  = {4{$urandom}};
      if (!k_rv_off && (bus_dat.size() > 0) && (bus_due[0] <= cyc) && ($urandom_range(99) < k_rv)) begin
         mem_rvalid = 1'b1;
         mem_rdata  = bus_dat.pop_front();
         void'(bus_due.pop_front());
      end
      if (mem_req && mem_gnt) begin
         lat = $urandom_range(k_lat_max, k_lat_min);
         bus_dat.push_back(mkdata(mem_addr));
         bus_due.push_back(cyc + lat);
         n_acc++;
      end
      if (exp_req) req_wait++;
      if (m_sd) sd_cnt++;

      // Model update
      acc   = exp_req && mem_gnt;
      pop   = codec_data_rd_en && (fifo_q.size() != 0) && m_sd;
      uf    = codec_data_rd_en && (fifo_q.size() == 0) && m_sd;
      rv_ok = mem_rvalid && (m_out > 0);
      n_sd  = m_sd;
      if (m_done) n_sd = 1'b0;
      else if (m_busy && (m_len != 0) && (fifo_q.size() >= m_prime)) n_sd = 1'b1;
      if (pop) begin
         ea = m_base + 16'(m_consumed);
         chk("pop_data", codec_data, mkdata(ea));
         void'(fifo_q.pop_front());
         m_consumed++;
      end
      if (rv_ok) begin
         fifo_q.push_back(mem_rdata);
         m_out--;
      end
      if (acc) begin
         m_issued++;
         m_out++;
      end
      if (uf) m_uf = 1'b1;
      n_busy = m_busy;
      n_done = 1'b0;
      if (m_done) n_busy = 1'b0;
      else if (m_busy) n_done = pop && (m_consumed == m_len);
      else if (start) begin
         m_base = cfg_base_addr; m_len = int'(cfg_slice_words);
         m_prime = (m_len < DEPTH) ? m_len : DEPTH;
         m_issued = 0; m_consumed = 0;
         n_busy = 1'b1; n_done = (m_len == 0);
      end
      m_busy = n_busy; m_done = n_done; m_sd = n_sd;
      if (k_rst) begin
         m_busy = 0; m_done = 0; m_sd = 0; m_uf = 0; m_base = '0;
         m_len = 0; m_prime = 0; m_issued = 0; m_consumed = 0; m_out = 0;
         fifo_q.delete();
      end
      cyc++;
   endtask

   task automatic set_knobs(input int gnt, rv, lmin, lmax, rd, rd_hold, gnt_hold, noise);
      k_gnt = gnt; k_rv = rv; k_lat_min = lmin; k_lat_max = lmax; k_rd = rd;
      k_rd_hold = rd_hold; k_gnt_hold = gnt_hold; k_noise = noise;
      req_wait = 0; sd_cnt = 0; n_acc = 0; n_done_seen = 0;
   endtask

   task automatic run_slice(input logic [15:0] b, input int l,
                            input int gnt, rv, lmin, lmax, rd, rd_hold, gnt_hold, noise);
      int n;
      salt = salt + 32'd1;
      set_knobs(gnt, rv, lmin, lmax, rd, rd_hold, gnt_hold, noise);
      k_start = 1; k_base = b; k_len = 16'(l);
      cycle();
      k_start = 0;
      n = 0;
      while (m_busy && (n < 4000)) begin
         cycle();
         n++;
      end
      chk("slice_end", m_busy, 1'b0);
      chk("done_pulses", n_done_seen, 1);
      chk("req_count", n_acc, l);
   endtask

   initial begin
      int n;
      rst = 1; start = 0; cfg_base_addr = '0; cfg_slice_words = '0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; codec_data_rd_en = 0;

      k_rst = 1;
      repeat (3) cycle();
      k_rst = 0; k_zero = 1;
      repeat (2) cycle();
      k_zero = 0;

      run_slice(16'h0010, 8, 100, 100, 2, 2, 100, 0, 0, 0);   // basic
      run_slice(16'h0200, 6, 100, 100, 1, 3, 100, 20, 0, 0);  // consumer backpressure
      run_slice(16'h0300, 2, 100, 100, 1, 2, 100, 0, 0, 0);   // short slice
      run_slice(16'h0777, 0, 100, 100, 1, 1, 100, 0, 0, 0);   // empty slice
      run_slice(16'hFFFE, 4, 100, 100, 1, 2, 100, 0, 5, 0);   // grant stall and wrap
      run_slice(16'h1000, 10, 70, 40, 1, 5, 100, 0, 0, 20);   // underflow, busy starts

      // Abort with two reads in flight; their late returns must be dropped
      salt = salt + 32'd1;
      set_knobs(100, 100, 1, 1, 0, 0, 0, 0);
      k_rv_off = 1;
      k_start = 1; k_base = 16'h0400; k_len = 16'd8;
      cycle();
      k_start = 0;
      n = 0;
      while ((m_out < 2) && (n < 50)) begin
         cycle();
         n++;
      end
      chk("inflight_before_rst", bus_dat.size(), 2);
      k_gnt_off = 1; k_rst = 1;
      repeat (2) cycle();
      k_rst = 0; k_gnt_off = 0; k_rv_off = 0; k_zero = 1;
      n = 0;
      while ((bus_dat.size() > 0) && (n < 50)) begin
         cycle();
         n++;
      end
      repeat (3) cycle();
      k_zero = 0;
      chk("stale_returns_drained", bus_dat.size(), 0);
      run_slice(16'h0500, 3, 100, 100, 1, 2, 100, 0, 0, 0);

      for (int i = 0; i < 6; i++) begin
         run_slice(16'($urandom), $urandom_range(20, 1), $urandom_range(100, 30),
                   $urandom_range(100, 30), 1, $urandom_range(6, 1), $urandom_range(100, 20),
                   $urandom_range(10, 0), $urandom_range(3, 0), $urandom_range(15, 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
